// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//   Registered control FSM for a multi-cycle MIPS datapath. It decodes the
//   instruction register and drives every datapath write enable and mux
//   select. It also adds memory wait states, branch resolution in EX, an
//   illegal-instruction trap, and a counter of retired instructions.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   instruction           current IR contents
//   mem_ready             memory access completes this cycle
//   alu_zero              ALU result is zero (branch compare)
//   state                 IF=0 ID=1 EX=2 MEM=3 WB=4 TRAP=5
//   pc_we..mem_we         datapath write enables
//   mem_in                memory address select: 0 PC, 1 ALUOut
//   reg_dst               register file write address: 0 rt, 1 rd, 2 LINK_REG
//   reg_in                register file write data: 0 ALUOut, 1 MDR, 2 PC
//   alu_src_a/alu_src_b   ALU operand selects
//   imm_zext              immediate operand is zero-extended (XORI)
//   alu_op                0 ADD, 1 SUB, 2 XOR, 3 SLT
//   pc_src                0 ALU, 1 ALUOut, 2 jump target, 3 A
//   illegal               high while trapped
//   instr_done            one-cycle pulse on each transition into IF
//   instr_count           retired-instruction counter (wraps)
module mc_control_fsm #(
  parameter int LINK_REG    = 31,
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit TRAP_EN     = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruction,
  input  logic             mem_ready,
  input  logic             alu_zero,
  output logic [2:0]       state,
  output logic             pc_we,
  output logic             ir_we,
  output logic             a_we,
  output logic             b_we,
  output logic             reg_we,
  output logic             mem_we,
  output logic             mem_in,
  output logic [1:0]       reg_dst,
  output logic [1:0]       reg_in,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             imm_zext,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // The link register index is consumed by the datapath's reg_dst mux; the
  // controller only selects it.
  localparam logic [4:0] LINK_ADDR = 5'(LINK_REG);

  state_t     cur_state;
  state_t     nxt_state;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ready;
  logic       is_r_alu;
  logic       is_jr;
  logic       legal;
  logic       unused_bits;

  assign opcode      = instruction[31:26];
  assign funct       = instruction[5:0];
  assign unused_bits = ^{instruction[25:6], LINK_ADDR};
  assign state       = cur_state;

  // With wait states disabled the memory is assumed to answer every cycle.
  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  assign is_r_alu = (opcode == OP_RTYPE) &&
                    ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT));
  assign is_jr    = (opcode == OP_RTYPE) && (funct == FN_JR);

  always_comb begin
    case (opcode)
      OP_RTYPE: legal = is_r_alu || is_jr;
      OP_J, OP_JAL, OP_BEQ, OP_BNE,
      OP_ADDI, OP_XORI, OP_LW, OP_SW: legal = 1'b1;
      default:  legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= S_IF;
    else        cur_state <= nxt_state;
  end

  // Retirement is counted on the pulse, so a trapped or reset-aborted
  // instruction never reaches the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          instr_count <= '0;
    else if (instr_done) instr_count <= instr_count + 1'b1;
  end

  // Every output is forced low while reset is asserted, which is why the
  // case body sits under the rst_n test rather than relying on the state.
  always_comb begin
    nxt_state  = cur_state;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    a_we       = 1'b0;
    b_we       = 1'b0;
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    mem_in     = 1'b0;
    reg_dst    = 2'd0;
    reg_in     = 2'd0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    imm_zext   = 1'b0;
    alu_op     = 3'd0;
    pc_src     = 2'd0;
    illegal    = 1'b0;
    instr_done = 1'b0;
    if (rst_n) begin
      case (cur_state)
        S_IF: begin
          alu_src_b = 2'd1;
          pc_we     = ready;
          ir_we     = ready;
          if (ready) nxt_state = S_ID;
        end
        S_ID: begin
          a_we      = 1'b1;
          b_we      = 1'b1;
          alu_src_b = 2'd3;
          if (opcode == OP_J) begin
            pc_we     = 1'b1;
            pc_src    = 2'd2;
            nxt_state = S_IF;
          end else if (!legal) begin
            nxt_state = TRAP_EN ? S_TRAP : S_IF;
          end else begin
            nxt_state = S_EX;
          end
        end
        S_EX: begin
          nxt_state = S_WB;
          case (opcode)
            OP_LW, OP_SW: begin
              alu_src_a = 2'd1;
              alu_src_b = 2'd2;
              nxt_state = S_MEM;
            end
            OP_ADDI: begin
              alu_src_a = 2'd1;
              alu_src_b = 2'd2;
            end
            OP_XORI: begin
              alu_src_a = 2'd1;
              alu_src_b = 2'd2;
              imm_zext  = 1'b1;
              alu_op    = 3'd2;
            end
            OP_JAL: begin
              reg_we    = 1'b1;
              reg_dst   = 2'd2;
              reg_in    = 2'd2;
              pc_we     = 1'b1;
              pc_src    = 2'd2;
              nxt_state = S_IF;
            end
            OP_BEQ, OP_BNE: begin
              alu_src_a = 2'd1;
              alu_op    = 3'd1;
              pc_src    = 2'd1;
              pc_we     = (opcode == OP_BEQ) ? alu_zero : !alu_zero;
              nxt_state = S_IF;
            end
            default: begin
              if (is_jr) begin
                pc_we     = 1'b1;
                pc_src    = 2'd3;
                nxt_state = S_IF;
              end else begin
                alu_src_a = 2'd1;
                case (funct)
                  FN_SUB:  alu_op = 3'd1;
                  FN_SLT:  alu_op = 3'd3;
                  default: alu_op = 3'd0;
                endcase
              end
            end
          endcase
        end
        S_MEM: begin
          mem_in = 1'b1;
          // The store strobe stays up until memory accepts it.
          if (opcode == OP_SW) begin
            mem_we = 1'b1;
            if (ready) nxt_state = S_IF;
          end else if (ready) begin
            nxt_state = S_WB;
          end
        end
        S_WB: begin
          reg_we    = 1'b1;
          nxt_state = S_IF;
          if (opcode == OP_LW)         reg_in  = 2'd1;
          else if (opcode == OP_RTYPE) reg_dst = 2'd1;
        end
        S_TRAP: begin
          illegal = 1'b1;
        end
        default: nxt_state = S_IF;
      endcase
      instr_done = (cur_state != S_IF) && (nxt_state == S_IF);
    end
  end

endmodule
